// File: rtl/load_store_unit.sv
// Load/store unit: bridges the core datapath to a req/gnt/rvalid data bus,
// stalling the core while a transfer is outstanding.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessFault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    logic [1:0]  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] cnt;
    logic        fault_q;

    logic        access;
    logic        legal;
    logic        aligned;
    logic        start;
    logic        timeout_hit;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] ld_data;

    assign access = MemRead | MemWrite;

    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        be_n    = 4'b1111;
        wdata_n = WriteData;
        unique case (Funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = MemRead;
            default:                legal = 1'b0;
        endcase
        unique case (Funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << ALUResult[1:0];
                wdata_n = {4{WriteData[7:0]}};
            end
            2'b01: begin
                aligned = ~ALUResult[0];
                be_n    = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{WriteData[15:0]}};
            end
            default: aligned = (ALUResult[1:0] == 2'b00);
        endcase
    end

    assign start = (state == S_IDLE) && access && legal && aligned;

    assign Stall = start || (state == S_REQ) || (state == S_WAIT);
    assign AccessFault = fault_q ||
        ((state == S_IDLE) && access && !(legal && aligned));
    assign bus_req = (state == S_REQ);

    // Watchdog fires on the cycle that would be the TIMEOUT-th busy cycle.
    assign timeout_hit = (TO != 16'd0) && ((cnt + 16'd1) == TO);

    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        half    = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (f3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{half[15]}}, half};
            3'b100:  ld_data = {24'd0, shifted[7:0]};
            3'b101:  ld_data = {16'd0, half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            cnt       <= 16'd0;
            fault_q   <= 1'b0;
            ReadData  <= 32'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            fault_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        bus_addr  <= {ALUResult[31:2], 2'b00};
                        bus_we    <= MemWrite;
                        bus_be    <= be_n;
                        bus_wdata <= wdata_n;
                        f3_q      <= Funct3;
                        off_q     <= ALUResult[1:0];
                        cnt       <= 16'd0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (timeout_hit) begin
                        fault_q  <= 1'b1;
                        ReadData <= 32'd0;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (bus_gnt) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus_rvalid) begin
                        if (!bus_we) begin
                            ReadData <= ld_data;
                        end
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        fault_q  <= 1'b1;
                        ReadData <= 32'd0;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: randomized loads/stores with a transaction-level
// model predicting every cycle, plus directed cases with literal results.
module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, AccessFault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    bit          e_v = 1'b0;
    bit          e_stall, e_fault, e_req, e_bus, e_we;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_be;
    logic [31:0] model_rd = 32'd0;

    int stall_cnt, req_cnt, fault_cnt;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_legal(bit rd, bit wr, logic [2:0] f3);
        if (rd) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if (wr) return f3 inside {3'd0, 3'd1, 3'd2};
        return 1'b0;
    endfunction

    function automatic int model_size(logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, int off,
                                                logic [31:0] data);
        longint v;
        v = longint'(data >> (8 * off));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v -= 256;   end
            3'd1: begin v = v % 65536; if (v >= 32768) v -= 65536; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = longint'(data);
        endcase
        return v[31:0];
    endfunction

    // Single compare point: every cycle with a prediction is checked here.
    always @(negedge clk) begin
        if (Stall === 1'b1) stall_cnt++;
        if (bus_req === 1'b1) req_cnt++;
        if (AccessFault === 1'b1) fault_cnt++;
        if (e_v) begin
            chk("stall", 32'(Stall), 32'(e_stall));
            chk("fault", 32'(AccessFault), 32'(e_fault));
            chk("req", 32'(bus_req), 32'(e_req));
            chk("readdata", ReadData, e_rd);
            if (e_bus) begin
                chk("we", 32'(bus_we), 32'(e_we));
                chk("addr", bus_addr, e_addr);
                chk("be", 32'(bus_be), 32'(e_be));
                chk("wdata", bus_wdata, e_wdata);
            end
        end
    end

    task automatic set_exp(bit st, bit fl, bit rq, bit bs);
        e_v = 1'b1; e_stall = st; e_fault = fl; e_req = rq; e_bus = bs;
        e_rd = model_rd;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0;
        Funct3 = 3'($urandom); ALUResult = $urandom; WriteData = $urandom;
        bus_gnt = 0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
        set_exp(0, 0, 0, 0);
    endtask

    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int g, input int r, input logic [31:0] rdata);
        int sz, off, t, n;
        bit ok, abort;
        sz  = model_size(f3);
        off = int'(addr % 4);
        ok  = model_legal(rd, wr, f3) && (addr % sz == 0);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; Funct3 = f3;
        ALUResult = addr; WriteData = wd;
        bus_gnt = 0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
        stall_cnt = 0; req_cnt = 0; fault_cnt = 0;
        if (!ok) begin
            set_exp(0, 1, 0, 0);
        end else begin
            e_addr = addr - 32'(off);
            e_be   = 4'(((1 << sz) - 1) << off);
            e_we   = wr;
            if (sz == 1) e_wdata = (wd % 256) * 32'h0101_0101;
            else if (sz == 2) e_wdata = (wd % 65536) * 32'h0001_0001;
            else e_wdata = wd;
            set_exp(1, 0, 0, 0);
            t     = g + r + 2;
            n     = (t < TO) ? t : TO;
            abort = (t > TO);
            for (int k = 1; k <= n; k++) begin
                @(posedge clk); #1;
                if (k <= g + 1) begin
                    bus_gnt = (k == g + 1);
                    bus_rvalid = 1'($urandom); bus_rdata = $urandom;
                    set_exp(1, 0, 1, 1);
                end else begin
                    bus_gnt = 0;
                    bus_rvalid = (k == t);
                    bus_rdata = (k == t) ? rdata : $urandom;
                    set_exp(1, 0, 0, 0);
                end
            end
            @(posedge clk); #1;
            bus_gnt = 0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
            if (abort) model_rd = 32'd0;
            else if (rd) model_rd = model_load(f3, off, rdata);
            set_exp(0, abort, 0, 0);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        bit          rd;
        reset = 0; MemRead = 0; MemWrite = 0; Funct3 = 0;
        ALUResult = 0; WriteData = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_fault", 32'(AccessFault), 32'd0);
        @(posedge clk); #1;
        reset = 1;

        chk("pin_lb", model_load(3'd0, 3, 32'h80FF_1234), 32'hFFFF_FF80);
        chk("pin_lbu", model_load(3'd4, 3, 32'h80FF_1234), 32'h0000_0080);
        chk("pin_lhu", model_load(3'd5, 2, 32'h80FF_1234), 32'h0000_80FF);
        chk("pin_lh", model_load(3'd1, 0, 32'h0000_9000), 32'hFFFF_9000);

        run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("lw_addr", bus_addr, 32'h100);
        chk("lw_be", 32'(bus_be), 32'hF);
        chk("lw_data", ReadData, 32'hDEAD_BEEF);

        run_op(1, 0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80FF_1234);
        chk("lb_be", 32'(bus_be), 32'h8);
        chk("lb_data", ReadData, 32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 32'h203, 32'h0, 1, 0, 32'h80FF_1234);
        chk("lbu_data", ReadData, 32'h0000_0080);
        run_op(1, 0, 3'b101, 32'h202, 32'h0, 0, 1, 32'h80FF_1234);
        chk("lhu_data", ReadData, 32'h0000_80FF);

        run_op(0, 1, 3'b000, 32'h41, 32'h1234_56AB, 0, 0, 32'h0);
        chk("sb_we", 32'(bus_we), 32'd1);
        chk("sb_be", 32'(bus_be), 32'h2);
        chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
        run_op(0, 1, 3'b001, 32'h42, 32'h0000_BEEF, 0, 0, 32'h0);
        chk("sh_be", 32'(bus_be), 32'hC);
        chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        chk("sh_keeps_rd", ReadData, 32'h0000_80FF);

        run_op(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0);
        chk("mis_lw_fault", 32'(fault_cnt), 32'd1);
        chk("mis_lw_req", 32'(req_cnt), 32'd0);
        run_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0);
        chk("mis_lh_stall", 32'(stall_cnt), 32'd0);
        run_op(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        chk("ill_f3_req", 32'(req_cnt), 32'd0);
        idle_cycle();

        run_op(1, 0, 3'b010, 32'h180, 32'h0, 3, 1, 32'h1357_9BDF);
        chk("slow_req_cycles", 32'(req_cnt), 32'd4);
        chk("slow_stall_cycles", 32'(stall_cnt), 32'd7);
        chk("slow_data", ReadData, 32'h1357_9BDF);

        run_op(1, 0, 3'b010, 32'h1C0, 32'h0, 50, 0, 32'h0);
        chk("to_req_cycles", 32'(req_cnt), 32'(TO));
        chk("to_fault", 32'(fault_cnt), 32'd1);
        chk("to_data", ReadData, 32'd0);
        run_op(1, 0, 3'b010, 32'h1C4, 32'h0, 0, 0, 32'h2468_ACE0);
        chk("after_to", ReadData, 32'h2468_ACE0);

        // Reset in the middle of a transfer.
        @(posedge clk); #1;
        MemRead = 1; MemWrite = 0; Funct3 = 3'b010; ALUResult = 32'h300;
        bus_gnt = 0; bus_rvalid = 0;
        set_exp(1, 0, 0, 0);
        @(posedge clk); #1;
        bus_gnt = 1;
        set_exp(1, 0, 1, 0);
        @(posedge clk); #1;
        bus_gnt = 0;
        set_exp(1, 0, 0, 0);
        #2;
        e_v = 0; reset = 0; MemRead = 0;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_stall", 32'(Stall), 32'd0);
        chk("mid_rst_rd", ReadData, 32'd0);
        chk("mid_rst_addr", bus_addr, 32'd0);
        chk("mid_rst_be", 32'(bus_be), 32'd0);
        chk("mid_rst_fault", 32'(AccessFault), 32'd0);
        model_rd = 32'd0;
        @(posedge clk); #1;
        reset = 1;
        idle_cycle();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle();
            end else begin
                rd = 1'($urandom);
                f3 = 3'($urandom);
                a  = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (f3[1:0] == 2'd1) a[0] = 1'b0;
                    else if (f3[1:0] != 2'd0) a[1:0] = 2'b00;
                end
                run_op(rd, !rd, f3, a, $urandom,
                       $urandom_range(0, 5), $urandom_range(0, 4), $urandom);
            end
        end
        idle_cycle();
        @(negedge clk); #1;
        e_v = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
